// File: rtl/ddr_burst_pkg.sv
// Shared types and default constants for the DDR burst responder.
package ddr_burst_pkg;

  localparam int LEN_W              = 10;
  localparam int TMR_W              = 8;
  localparam int DEF_DATA_W         = 128;
  localparam int DEF_ADDR_W         = 28;
  localparam int DEF_MEM_AW         = 10;
  localparam int DEF_ADDR_STEP_LOG2 = 3;
  localparam int DEF_RD_LATENCY     = 2;
  localparam int DEF_GAP_CYCLES     = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_REQ,
    ST_WR_LAST,
    ST_RD_WAIT,
    ST_RD_DATA,
    ST_FINISH,
    ST_GAP
  } state_t;

endpackage

// File: rtl/ddr_burst_if.sv
// Burst request/data bus between a memory-controller-side master and the responder.
interface ddr_burst_if #(
  parameter int DATA_W = ddr_burst_pkg::DEF_DATA_W,
  parameter int ADDR_W = ddr_burst_pkg::DEF_ADDR_W
);
  import ddr_burst_pkg::*;

  logic              rd_burst_req;
  logic              wr_burst_req;
  logic [LEN_W-1:0]  rd_burst_len;
  logic [LEN_W-1:0]  wr_burst_len;
  logic [ADDR_W-1:0] rd_burst_addr;
  logic [ADDR_W-1:0] wr_burst_addr;
  logic [DATA_W-1:0] wr_burst_data;
  logic              wr_burst_data_req;
  logic              rd_burst_data_valid;
  logic [DATA_W-1:0] rd_burst_data;
  logic              rd_burst_finish;
  logic              wr_burst_finish;
  logic              busy;

  modport master (
    output rd_burst_req, wr_burst_req, rd_burst_len, wr_burst_len,
           rd_burst_addr, wr_burst_addr, wr_burst_data,
    input  wr_burst_data_req, rd_burst_data_valid, rd_burst_data,
           rd_burst_finish, wr_burst_finish, busy
  );

  modport slave (
    input  rd_burst_req, wr_burst_req, rd_burst_len, wr_burst_len,
           rd_burst_addr, wr_burst_addr, wr_burst_data,
    output wr_burst_data_req, rd_burst_data_valid, rd_burst_data,
           rd_burst_finish, wr_burst_finish, busy
  );

endinterface

// File: rtl/ddr_burst_mem.sv
// Backing store: simple dual-port RAM, one write port and one registered read port.
module ddr_burst_mem #(
  parameter int DATA_W = 128,
  parameter int AW     = 10
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [AW-1:0]     i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [AW-1:0]     i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [0:(1<<AW)-1];
  logic [DATA_W-1:0] r_q;

  // No reset: contents must survive a responder reset.
  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) r_q <= r_mem[i_raddr];
  end

  assign o_rdata = r_q;

endmodule

// File: rtl/ddr_burst_responder.sv
// DDR burst responder: serves level-requested read/write bursts against an internal
// beat-indexed store, with a fixed read latency and a quiet gap after each burst.
module ddr_burst_responder
  import ddr_burst_pkg::*;
#(
  parameter int DDR_DATA_WIDTH = DEF_DATA_W,
  parameter int DDR_ADDR_WIDTH = DEF_ADDR_W,
  parameter int MEM_AW         = DEF_MEM_AW,
  parameter int ADDR_STEP_LOG2 = DEF_ADDR_STEP_LOG2,
  parameter int RD_LATENCY     = DEF_RD_LATENCY,
  parameter int GAP_CYCLES     = DEF_GAP_CYCLES
) (
  input logic        mem_clk,
  input logic        rst,
  ddr_burst_if.slave bus
);

  localparam int RD_WAIT_INIT = RD_LATENCY - 2;
  localparam int GAP_INIT     = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

  state_t              r_state;
  logic [LEN_W-1:0]    r_cnt;
  logic [TMR_W-1:0]    r_tmr;
  logic [MEM_AW-1:0]   r_wr_idx;
  logic [MEM_AW-1:0]   r_rd_idx;
  logic                r_wr_data_req;
  logic                r_wr_cap;
  logic                r_rd_valid;
  logic                r_rd_finish;
  logic                r_wr_finish;
  logic                r_busy;

  logic [MEM_AW-1:0]         w_wr_base;
  logic [MEM_AW-1:0]         w_rd_base;
  logic                      w_rd_en;
  logic [DDR_DATA_WIDTH-1:0] w_mem_q;

  // Upper address bits are dropped on purpose so bursts wrap around the store.
  assign w_wr_base = bus.wr_burst_addr[ADDR_STEP_LOG2 +: MEM_AW];
  assign w_rd_base = bus.rd_burst_addr[ADDR_STEP_LOG2 +: MEM_AW];
  assign w_rd_en   = (r_state == ST_RD_WAIT) || (r_state == ST_RD_DATA);

  always_ff @(posedge mem_clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_cnt         <= '0;
      r_tmr         <= '0;
      r_wr_idx      <= '0;
      r_rd_idx      <= '0;
      r_wr_data_req <= 1'b0;
      r_wr_cap      <= 1'b0;
      r_rd_valid    <= 1'b0;
      r_rd_finish   <= 1'b0;
      r_wr_finish   <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_wr_cap    <= r_wr_data_req;
      r_wr_finish <= 1'b0;
      r_rd_finish <= 1'b0;
      if (r_wr_cap) r_wr_idx <= r_wr_idx + 1'b1;
      case (r_state)
        ST_IDLE: begin
          if (bus.wr_burst_req) begin
            r_busy   <= 1'b1;
            r_wr_idx <= w_wr_base;
            r_cnt    <= bus.wr_burst_len;
            if (bus.wr_burst_len == '0) begin
              r_state     <= ST_FINISH;
              r_wr_finish <= 1'b1;
            end else begin
              r_state       <= ST_WR_REQ;
              r_wr_data_req <= 1'b1;
            end
          end else if (bus.rd_burst_req) begin
            r_busy   <= 1'b1;
            r_rd_idx <= w_rd_base;
            r_cnt    <= bus.rd_burst_len;
            r_tmr    <= TMR_W'(RD_WAIT_INIT);
            if (bus.rd_burst_len == '0) begin
              r_state     <= ST_FINISH;
              r_rd_finish <= 1'b1;
            end else begin
              r_state <= ST_RD_WAIT;
            end
          end
        end
        ST_WR_REQ: begin
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == LEN_W'(1)) begin
            r_state       <= ST_WR_LAST;
            r_wr_data_req <= 1'b0;
          end
        end
        ST_WR_LAST: begin
          r_state     <= ST_FINISH;
          r_wr_finish <= 1'b1;
        end
        // The last wait cycle already presents the base index to the RAM.
        ST_RD_WAIT: begin
          if (r_tmr == '0) begin
            r_state    <= ST_RD_DATA;
            r_rd_valid <= 1'b1;
            r_rd_idx   <= r_rd_idx + 1'b1;
          end else begin
            r_tmr <= r_tmr - 1'b1;
          end
        end
        ST_RD_DATA: begin
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == LEN_W'(1)) begin
            r_state     <= ST_FINISH;
            r_rd_valid  <= 1'b0;
            r_rd_finish <= 1'b1;
          end else begin
            r_rd_idx <= r_rd_idx + 1'b1;
          end
        end
        ST_FINISH: begin
          if (GAP_CYCLES == 0) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_state <= ST_GAP;
            r_tmr   <= TMR_W'(GAP_INIT);
          end
        end
        ST_GAP: begin
          if (r_tmr == '0) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_tmr <= r_tmr - 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  ddr_burst_mem #(
    .DATA_W (DDR_DATA_WIDTH),
    .AW     (MEM_AW)
  ) u_mem (
    .i_clk   (mem_clk),
    .i_we    (r_wr_cap),
    .i_waddr (r_wr_idx),
    .i_wdata (bus.wr_burst_data),
    .i_re    (w_rd_en),
    .i_raddr (r_rd_idx),
    .o_rdata (w_mem_q)
  );

  assign bus.wr_burst_data_req   = r_wr_data_req;
  assign bus.rd_burst_data_valid = r_rd_valid;
  assign bus.rd_burst_data       = r_rd_valid ? w_mem_q : '0;
  assign bus.rd_burst_finish     = r_rd_finish;
  assign bus.wr_burst_finish     = r_wr_finish;
  assign bus.busy                = r_busy;

endmodule

// File: tb/tb_ddr_burst_responder.sv
// Directed bench for ddr_burst_responder; cycle k is observed at the k-th falling edge after acceptance.
module tb_ddr_burst_responder;
  import ddr_burst_pkg::*;

  logic mem_clk = 1'b0;
  logic rst;
  ddr_burst_if bus ();

  ddr_burst_responder dut (
    .mem_clk (mem_clk),
    .rst     (rst),
    .bus     (bus)
  );

  always #5 mem_clk = ~mem_clk;

  int checks = 0;
  int failures = 0;

  logic [127:0] wr_beats [0:15];
  logic [127:0] rd_beats [0:63];
  bit           busy_trace [0:127];
  int n_req, first_req, last_req, n_valid, first_valid;
  int wr_fin, rd_fin, n_wr_fin, n_rd_fin, bad_zero;

  task automatic run_burst(input bit do_wr, input bit do_rd,
                           input logic [9:0] wlen, input logic [27:0] waddr,
                           input logic [9:0] rlen, input logic [27:0] raddr);
    bit prev_req;
    bit done;
    int wi;
    n_req = 0; first_req = -1; last_req = -1; n_valid = 0; first_valid = -1;
    wr_fin = -1; rd_fin = -1; n_wr_fin = 0; n_rd_fin = 0; bad_zero = 0;
    foreach (busy_trace[i]) busy_trace[i] = 1'b0;
    @(negedge mem_clk);
    bus.wr_burst_req = do_wr; bus.wr_burst_len = wlen; bus.wr_burst_addr = waddr;
    bus.rd_burst_req = do_rd; bus.rd_burst_len = rlen; bus.rd_burst_addr = raddr;
    prev_req = 1'b0; done = 1'b0; wi = 0;
    for (int k = 1; k <= 120 && !done; k++) begin
      @(negedge mem_clk);
      busy_trace[k] = bus.busy;
      if (k == 1) bus.wr_burst_req = 1'b0;
      if (prev_req) begin
        bus.wr_burst_data = wr_beats[wi % 16];
        wi++;
      end else begin
        bus.wr_burst_data = '0;
      end
      prev_req = bus.wr_burst_data_req;
      if (bus.wr_burst_data_req) begin
        n_req++;
        if (first_req < 0) first_req = k;
        last_req = k;
      end
      if (bus.rd_burst_data_valid) begin
        if (first_valid < 0) first_valid = k;
        if (n_valid < 64) rd_beats[n_valid] = bus.rd_burst_data;
        n_valid++;
      end else if (bus.rd_burst_data !== '0) begin
        bad_zero++;
      end
      if (bus.wr_burst_finish) begin n_wr_fin++; if (wr_fin < 0) wr_fin = k; end
      if (bus.rd_burst_finish) begin n_rd_fin++; if (rd_fin < 0) rd_fin = k; end
      if (bus.rd_burst_data_valid || bus.rd_burst_finish) bus.rd_burst_req = 1'b0;
      if (!bus.busy && (!do_wr || wr_fin >= 0) && (!do_rd || rd_fin >= 0)) done = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.rd_burst_req = 0; bus.wr_burst_req = 0; bus.rd_burst_len = 0; bus.wr_burst_len = 0;
    bus.rd_burst_addr = 0; bus.wr_burst_addr = 0; bus.wr_burst_data = 0;
    repeat (3) @(negedge mem_clk);
    checks++;
    if ({bus.wr_burst_data_req, bus.rd_burst_data_valid, bus.rd_burst_finish,
         bus.wr_burst_finish, bus.busy} !== 5'b0) begin
      failures++;
      $display("FAIL reset_ctrl got=%b exp=00000", {bus.wr_burst_data_req, bus.rd_burst_data_valid,
               bus.rd_burst_finish, bus.wr_burst_finish, bus.busy});
    end
    checks++;
    if (bus.rd_burst_data !== '0) begin
      failures++; $display("FAIL reset_rd_data got=%h exp=0", bus.rd_burst_data);
    end
    rst = 1'b0;
  endtask

  task automatic test_write();
    for (int i = 0; i < 4; i++) wr_beats[i] = 128'(32'h11 + i);
    run_burst(1'b1, 1'b0, 10'd4, 28'h0008000, 10'd0, 28'h0);
    checks++; if (n_req !== 4) begin failures++; $display("FAIL wr4_req_count got=%0d exp=4", n_req); end
    checks++; if (first_req !== 1 || last_req !== 4) begin
      failures++; $display("FAIL wr4_req_window got=%0d..%0d exp=1..4", first_req, last_req); end
    checks++; if (wr_fin !== 6) begin failures++; $display("FAIL wr4_finish_cycle got=%0d exp=6", wr_fin); end
    checks++; if (n_wr_fin !== 1 || n_rd_fin !== 0) begin
      failures++; $display("FAIL wr4_finish_pulses got=%0d/%0d exp=1/0", n_wr_fin, n_rd_fin); end
    checks++; if (busy_trace[1] !== 1'b1) begin failures++; $display("FAIL wr4_busy got=0 exp=1"); end
    for (int i = 0; i < 13; i++) wr_beats[i] = 128'(32'h100 + i);
    run_burst(1'b1, 1'b0, 10'd13, 28'h0008020, 10'd0, 28'h0);
    checks++; if (n_req !== 13 || wr_fin !== 15) begin
      failures++; $display("FAIL wr13 got req=%0d fin=%0d exp req=13 fin=15", n_req, wr_fin); end
  endtask

  task automatic test_read_len17();
    logic [127:0] e;
    run_burst(1'b0, 1'b1, 10'd0, 28'h0, 10'd17, 28'h0008000);
    checks++; if (first_valid !== 2) begin failures++; $display("FAIL rd17_first_valid got=%0d exp=2", first_valid); end
    checks++; if (n_valid !== 17) begin failures++; $display("FAIL rd17_valid_count got=%0d exp=17", n_valid); end
    checks++; if (rd_fin !== 19 || n_rd_fin !== 1) begin
      failures++; $display("FAIL rd17_finish got=%0d x%0d exp=19 x1", rd_fin, n_rd_fin); end
    checks++; if (bad_zero !== 0) begin failures++; $display("FAIL rd17_data_zero got=%0d exp=0", bad_zero); end
    for (int i = 0; i < 17 && i < n_valid; i++) begin
      e = (i < 4) ? 128'(32'h11 + i) : 128'(32'h100 + i - 4);
      checks++;
      if (rd_beats[i] !== e) begin failures++; $display("FAIL rd17_beat%0d got=%h exp=%h", i, rd_beats[i], e); end
    end
  endtask

  task automatic test_len_zero();
    run_burst(1'b0, 1'b1, 10'd0, 28'h0, 10'd0, 28'h0008000);
    checks++; if (rd_fin !== 1 || n_valid !== 0) begin
      failures++; $display("FAIL rd0 got fin=%0d valid=%0d exp fin=1 valid=0", rd_fin, n_valid); end
    run_burst(1'b1, 1'b0, 10'd0, 28'h0008000, 10'd0, 28'h0);
    checks++; if (wr_fin !== 1 || n_req !== 0) begin
      failures++; $display("FAIL wr0 got fin=%0d req=%0d exp fin=1 req=0", wr_fin, n_req); end
    run_burst(1'b0, 1'b1, 10'd0, 28'h0, 10'd1, 28'h0008000);
    checks++; if (rd_beats[0] !== 128'h11 || n_valid !== 1) begin
      failures++; $display("FAIL wr0_untouched got=%h exp=11", rd_beats[0]); end
  endtask

  task automatic test_back_to_back();
    wr_beats[0] = 128'hA0; wr_beats[1] = 128'hA1;
    run_burst(1'b1, 1'b1, 10'd2, 28'h0000140, 10'd2, 28'h0000140);
    checks++; if (wr_fin !== 4 || n_req !== 2) begin
      failures++; $display("FAIL b2b_write got fin=%0d req=%0d exp fin=4 req=2", wr_fin, n_req); end
    checks++; if (busy_trace[8] !== 1'b0) begin failures++; $display("FAIL b2b_idle_slot got=1 exp=0"); end
    checks++; if (first_valid !== 10 || n_valid !== 2 || rd_fin !== 12) begin
      failures++; $display("FAIL b2b_read got first=%0d n=%0d fin=%0d exp 10/2/12", first_valid, n_valid, rd_fin); end
    checks++; if (rd_beats[0] !== 128'hA0 || rd_beats[1] !== 128'hA1) begin
      failures++; $display("FAIL b2b_raw got=%h,%h exp=a0,a1", rd_beats[0], rd_beats[1]); end
  endtask

  task automatic test_held_write();
    int fins [0:3];
    int nf;
    int nr;
    int wi;
    bit prev_req;
    wr_beats[0] = 128'hB0; wr_beats[1] = 128'hC0; wr_beats[2] = 128'hC1;
    nf = 0; nr = 0; wi = 0; prev_req = 1'b0;
    @(negedge mem_clk);
    bus.wr_burst_req = 1'b1; bus.wr_burst_len = 10'd1; bus.wr_burst_addr = 28'h0000190;
    for (int k = 1; k <= 40; k++) begin
      @(negedge mem_clk);
      if (k == 4) begin bus.wr_burst_len = 10'd2; bus.wr_burst_addr = 28'h00001E0; end
      if (prev_req) begin bus.wr_burst_data = wr_beats[wi % 16]; wi++; end
      else bus.wr_burst_data = '0;
      prev_req = bus.wr_burst_data_req;
      if (bus.wr_burst_data_req) nr++;
      if (bus.wr_burst_data_req && k > 4) bus.wr_burst_req = 1'b0;
      if (bus.wr_burst_finish) begin if (nf < 4) fins[nf] = k; nf++; end
    end
    checks++; if (nf !== 2 || nr !== 3) begin
      failures++; $display("FAIL held_count got fins=%0d reqs=%0d exp 2/3", nf, nr); end
    checks++; if (nf >= 2 && (fins[0] !== 3 || fins[1] !== 11)) begin
      failures++; $display("FAIL held_finish_cycles got=%0d,%0d exp=3,11", fins[0], fins[1]); end
    run_burst(1'b0, 1'b1, 10'd0, 28'h0, 10'd1, 28'h0000190);
    checks++; if (rd_beats[0] !== 128'hB0) begin failures++; $display("FAIL held_first got=%h exp=b0", rd_beats[0]); end
    run_burst(1'b0, 1'b1, 10'd0, 28'h0, 10'd2, 28'h00001E0);
    checks++; if (rd_beats[0] !== 128'hC0 || rd_beats[1] !== 128'hC1) begin
      failures++; $display("FAIL held_second got=%h,%h exp=c0,c1", rd_beats[0], rd_beats[1]); end
  endtask

  task automatic test_wrap();
    wr_beats[0] = 128'hD0; wr_beats[1] = 128'hD1;
    run_burst(1'b1, 1'b0, 10'd2, 28'hFFFFFF8, 10'd0, 28'h0);
    checks++; if (wr_fin !== 4) begin failures++; $display("FAIL wrap_write_fin got=%0d exp=4", wr_fin); end
    run_burst(1'b0, 1'b1, 10'd0, 28'h0, 10'd2, 28'h0001FF8);
    checks++; if (rd_beats[0] !== 128'hD0 || rd_beats[1] !== 128'hD1) begin
      failures++; $display("FAIL wrap_alias got=%h,%h exp=d0,d1", rd_beats[0], rd_beats[1]); end
    run_burst(1'b0, 1'b1, 10'd0, 28'h0, 10'd1, 28'h0000000);
    checks++; if (rd_beats[0] !== 128'hD1) begin failures++; $display("FAIL wrap_index0 got=%h exp=d1", rd_beats[0]); end
  endtask

  task automatic test_reset_mid_read();
    int nv;
    int nfin;
    int nact;
    bit hit;
    nv = 0; hit = 1'b0; nfin = 0; nact = 0;
    @(negedge mem_clk);
    bus.rd_burst_req = 1'b1; bus.rd_burst_len = 10'd8; bus.rd_burst_addr = 28'h0008020;
    for (int k = 1; k <= 20 && !hit; k++) begin
      @(negedge mem_clk);
      if (k == 1) bus.rd_burst_req = 1'b0;
      if (bus.rd_burst_data_valid) begin
        rd_beats[nv] = bus.rd_burst_data;
        nv++;
        if (nv == 3) hit = 1'b1;
      end
    end
    rst = 1'b1;
    #1;
    checks++; if (!hit) begin failures++; $display("FAIL rstmid_reach_beat3 got=%0d beats exp=3", nv); end
    checks++;
    if ({bus.wr_burst_data_req, bus.rd_burst_data_valid, bus.rd_burst_finish,
         bus.wr_burst_finish, bus.busy} !== 5'b0 || bus.rd_burst_data !== '0) begin
      failures++; $display("FAIL rstmid_outputs got valid=%b busy=%b data=%h exp all 0",
                           bus.rd_burst_data_valid, bus.busy, bus.rd_burst_data);
    end
    checks++; if (rd_beats[0] !== 128'h100 || rd_beats[1] !== 128'h101 || rd_beats[2] !== 128'h102) begin
      failures++; $display("FAIL rstmid_pre_beats got=%h,%h,%h exp=100,101,102", rd_beats[0], rd_beats[1], rd_beats[2]); end
    repeat (2) @(negedge mem_clk);
    rst = 1'b0;
    repeat (20) begin
      @(negedge mem_clk);
      if (bus.rd_burst_finish || bus.wr_burst_finish) nfin++;
      if (bus.rd_burst_data_valid || bus.busy) nact++;
    end
    checks++; if (nfin !== 0 || nact !== 0) begin
      failures++; $display("FAIL rstmid_abandon got fins=%0d active=%0d exp 0/0", nfin, nact); end
    run_burst(1'b0, 1'b1, 10'd0, 28'h0, 10'd8, 28'h0008020);
    checks++; if (n_valid !== 8 || rd_fin !== 10) begin
      failures++; $display("FAIL rstmid_reread got n=%0d fin=%0d exp 8/10", n_valid, rd_fin); end
    for (int i = 0; i < 8 && i < n_valid; i++) begin
      checks++;
      if (rd_beats[i] !== 128'(32'h100 + i)) begin
        failures++; $display("FAIL rstmid_beat%0d got=%h exp=%h", i, rd_beats[i], 128'(32'h100 + i)); end
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read_len17();
    test_len_zero();
    test_back_to_back();
    test_held_write();
    test_wrap();
    test_reset_mid_read();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout got=running exp=finished");
    $fatal(1, "watchdog");
  end

endmodule
